render_window_buffer: RTL and testbench
=======================================

RENDER_WINDOW_BUFFER -- requirements
Module: render_window_buffer

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- START_X, 390, first window column.
- START_Y, 390, first window row.
- END_X, 634, column past the window.
- END_Y, 765, row past the window.
- BAND_DIVIDE, 530, first row of the lower band.
- UPPER_OFFSET, 2, write x-skew for the upper band.
- LOWER_OFFSET, 0, write x-skew for the lower band.
- COLOR_BITS, 4, output bits per channel.
- DOUBLE_BUFFER, 1, 1 selects two frame pages, 0 selects one page.
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk_in, input, 1, the only clock; all logic on its rising edge.
- rst_in, input, 1, reset; synchronous, active-high.
- wr_hcount_in, input, 11, renderer pixel column.
- wr_vcount_in, input, 10, renderer pixel row.
- wr_pixel_in, input, 24, RGB888 pixel value.
- wr_valid_in, input, 1, write pixel valid.
- wr_ready_out, output, 1, write pixel accepted when high together with wr_valid_in.
- wr_frame_done_in, input, 1, one-cycle pulse: renderer finished the frame.
- hcount_in, input, 11, VGA column.
- vcount_in, input, 10, VGA row.
- hs_in, input, 1, VGA horizontal sync.
- vs_in, input, 1, VGA vertical sync.
- ad_in, input, 1, VGA active draw.
- nf_in, input, 1, VGA new-frame pulse.
- red_out, output, COLOR_BITS, red channel.
- green_out, output, COLOR_BITS, green channel.
- blue_out, output, COLOR_BITS, blue channel.
- hs_out, output, 1, delayed horizontal sync.
- vs_out, output, 1, delayed vertical sync.
- swap_out, output, 1, one-cycle pulse on a page swap.
- front_sel_out, output, 1, index of the page being displayed.

Function
REQ-003 Window size: W=END_X-START_X, H=END_Y-START_Y, PAGE=W*H; RAM depth = PAGE*(1+DOUBLE_BUFFER).
REQ-004 Stored word: the top COLOR_BITS bits of each 8-bit channel of wr_pixel_in.
REQ-005 Write x: off = (wr_vcount_in<BAND_DIVIDE) ? UPPER_OFFSET : LOWER_OFFSET; x = wr_hcount_in-START_X-off, signed, 12 bits.
REQ-006 Write address: x + (wr_vcount_in-START_Y)*W + back_base, where back_base = PAGE*(~front_sel) if DOUBLE_BUFFER=1, else 0.
REQ-007 Out-of-window writes (x<0, x>=W, or row outside [START_Y,END_Y)) are accepted and dropped; no RAM write occurs.
REQ-008 Write state machine has two states.
- FILL: wr_ready_out=1.
- PENDING: wr_ready_out=0.
REQ-009 FILL -> PENDING on wr_frame_done_in. A pixel accepted in the same cycle is still written.
REQ-010 PENDING -> FILL on nf_in. In the same cycle: front_sel toggles and swap_out pulses for one cycle.
REQ-011 wr_frame_done_in and nf_in in the same cycle in FILL: enter PENDING. The swap waits for the next nf_in.
REQ-012 wr_frame_done_in in PENDING is ignored.
REQ-013 DOUBLE_BUFFER=0: the state stays FILL, wr_ready_out=1, swap_out=0 and front_sel_out=0 permanently.
REQ-014 Read address: (hcount_in-START_X) + (vcount_in-START_Y)*W + PAGE*front_sel, used when the VGA pixel is inside the window. Outside the window the read address is 0.
REQ-015 Read latency is exactly 2 cycles from hcount_in/vcount_in to RGB.
- hs_out, vs_out, in-window and ad_in are delayed by 2 registers to match.
REQ-016 RGB outputs are 0 unless both the delayed in-window flag and the delayed ad_in are 1.
REQ-017 A same-address read and write in one cycle returns the old data (read-first).
REQ-018 All address arithmetic is unsigned, 18 bits minimum. There is no wrap-around; out-of-range rows are gated by REQ-007 and REQ-014.

Reset
REQ-019 rst_in forces these values on the next edge:
- state FILL, wr_ready_out=1, front_sel_out=0, swap_out=0;
- RGB outputs 0, hs_out=0, vs_out=0, all delay registers 0.
REQ-020 Reset does not clear RAM contents. Reset during PENDING abandons the pending swap.

Structure
REQ-021 Package render_pkg holds the RGB888 and RGB444 pixel typedefs and the default window and band constants.
REQ-022 One sub-module, window_ram: simple dual-port, read-first, registered output, 2-cycle read latency, parameters for width and depth.

Verification
REQ-023 Write (wr_hcount_in=392, wr_vcount_in=390, pixel FFFFFF, upper band), then read at hcount_in=390, vcount_in=390, ad_in=1 -> 2 cycles later RGB = F,F,F.
REQ-024 Write (390,600,0x123456), lower band, then read (390,600) -> RGB = 1,3,5; write at (391,390), x=-1 -> no RAM change.
REQ-025 DOUBLE_BUFFER=1: fill page 1, pulse wr_frame_done_in -> wr_ready_out=0. Then nf_in -> swap_out pulses, front_sel_out=1, page 1 is displayed, wr_ready_out=1.
REQ-026 wr_frame_done_in and nf_in in the same cycle -> no swap. The next nf_in -> swap.
REQ-027 Reset asserted in PENDING -> front_sel_out=0, wr_ready_out=1, previously written pixels still read back.
REQ-028 hcount_in=389 or ad_in=0 inside the window -> RGB=0. hs_in toggles -> hs_out follows exactly 2 cycles later.

Source files
------------

// File: rtl/render_pkg.sv
// Shared pixel types and default window geometry for the render window buffer.
`timescale 1ns/1ps
package render_pkg;

  localparam int DEF_START_X      = 390;
  localparam int DEF_START_Y      = 390;
  localparam int DEF_END_X        = 634;
  localparam int DEF_END_Y        = 765;
  localparam int DEF_BAND_DIVIDE  = 530;
  localparam int DEF_UPPER_OFFSET = 2;
  localparam int DEF_LOWER_OFFSET = 0;
  localparam int MIN_ADDR_W       = 18;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Address width never drops below 18 bits so the arithmetic has headroom.
  function automatic int addr_width(input int depth);
    return ($clog2(depth) > MIN_ADDR_W) ? $clog2(depth) : MIN_ADDR_W;
  endfunction

endpackage

// File: rtl/render_window_ram.sv
// Simple dual-port read-first RAM with a two-stage registered read path.
`timescale 1ns/1ps
module window_ram #(
  parameter int WIDTH  = 12,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 18
) (
  input  logic              clk_in,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_q1;
  logic [WIDTH-1:0] r_rd_q2;

  // NOTE: the array is deliberately left out of reset so it maps onto block RAM;
  // the read captures the pre-write word, giving read-first behaviour.
  always_ff @(posedge clk_in) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rd_q1 <= r_mem[i_raddr];
    r_rd_q2 <= r_rd_q1;
  end

  assign o_rdata = r_rd_q2;

endmodule

// File: rtl/render_window_buffer.sv
// Windowed, optionally double-buffered frame store between a pixel renderer and a VGA scan-out.
`timescale 1ns/1ps
module render_window_buffer
  import render_pkg::*;
#(
  parameter int START_X       = DEF_START_X,
  parameter int START_Y       = DEF_START_Y,
  parameter int END_X         = DEF_END_X,
  parameter int END_Y         = DEF_END_Y,
  parameter int BAND_DIVIDE   = DEF_BAND_DIVIDE,
  parameter int UPPER_OFFSET  = DEF_UPPER_OFFSET,
  parameter int LOWER_OFFSET  = DEF_LOWER_OFFSET,
  parameter int COLOR_BITS    = 4,
  parameter int DOUBLE_BUFFER = 1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [10:0]           wr_hcount_in,
  input  logic [9:0]            wr_vcount_in,
  input  logic [23:0]           wr_pixel_in,
  input  logic                  wr_valid_in,
  output logic                  wr_ready_out,
  input  logic                  wr_frame_done_in,
  input  logic [10:0]           hcount_in,
  input  logic [9:0]            vcount_in,
  input  logic                  hs_in,
  input  logic                  vs_in,
  input  logic                  ad_in,
  input  logic                  nf_in,
  output logic [COLOR_BITS-1:0] red_out,
  output logic [COLOR_BITS-1:0] green_out,
  output logic [COLOR_BITS-1:0] blue_out,
  output logic                  hs_out,
  output logic                  vs_out,
  output logic                  swap_out,
  output logic                  front_sel_out
);

  localparam int W      = END_X - START_X;
  localparam int H      = END_Y - START_Y;
  localparam int PAGE   = W * H;
  localparam int DEPTH  = PAGE * (1 + DOUBLE_BUFFER);
  localparam int ADDR_W = addr_width(DEPTH);
  localparam int WORD_W = 3 * COLOR_BITS;

  typedef enum logic {
    ST_FILL,
    ST_PENDING
  } wr_state_e;

  wr_state_e r_state;
  wr_state_e w_state_next;
  logic      r_front_sel;
  logic      w_front_sel_next;
  logic      r_swap;
  logic      w_swap_next;

  // ---------------------------------------------------------------------------
  // Page-swap state machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= ST_FILL;
      r_front_sel <= 1'b0;
      r_swap      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_front_sel <= w_front_sel_next;
      r_swap      <= w_swap_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_state_next     = r_state;
    w_front_sel_next = r_front_sel;
    w_swap_next      = 1'b0;
    if (DOUBLE_BUFFER != 0) begin
      case (r_state)
        ST_FILL: begin
          if (wr_frame_done_in) begin
            w_state_next = ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (nf_in) begin
            w_state_next     = ST_FILL;
            w_front_sel_next = ~r_front_sel;
            w_swap_next      = 1'b1;
          end
        end
        default: w_state_next = ST_FILL;
      endcase
    end
  end

  assign wr_ready_out  = (r_state == ST_FILL);
  assign swap_out      = r_swap;
  assign front_sel_out = r_front_sel;

  // ---------------------------------------------------------------------------
  // Write path: band-dependent x skew, window clipping, back-page addressing
  // ---------------------------------------------------------------------------
  rgb888_t             w_wr_pix;
  int                  w_wr_off;
  logic signed [11:0]  w_wr_x;
  logic                w_wr_col_ok;
  logic                w_wr_row_ok;
  logic                w_wr_en;
  int                  w_back_base;
  logic [ADDR_W-1:0]   w_waddr;
  logic [WORD_W-1:0]   w_wdata;
  logic                w_unused_pix;

  assign w_wr_pix     = wr_pixel_in;
  assign w_unused_pix = ^wr_pixel_in;

  always_comb begin
    w_wr_off    = (int'(wr_vcount_in) < BAND_DIVIDE) ? UPPER_OFFSET : LOWER_OFFSET;
    w_wr_x      = 12'(int'(wr_hcount_in) - START_X - w_wr_off);
    w_wr_col_ok = (int'(w_wr_x) >= 0) && (int'(w_wr_x) < W);
    w_wr_row_ok = (int'(wr_vcount_in) >= START_Y) && (int'(wr_vcount_in) < END_Y);
    w_back_base = ((DOUBLE_BUFFER != 0) && !r_front_sel) ? PAGE : 0;
    w_wr_en     = wr_valid_in && wr_ready_out && w_wr_col_ok && w_wr_row_ok;
    w_waddr     = '0;
    if (w_wr_col_ok && w_wr_row_ok) begin
      w_waddr = ADDR_W'(int'(w_wr_x) + (int'(wr_vcount_in) - START_Y) * W + w_back_base);
    end
  end

  assign w_wdata = {w_wr_pix.r[7 -: COLOR_BITS],
                    w_wr_pix.g[7 -: COLOR_BITS],
                    w_wr_pix.b[7 -: COLOR_BITS]};

  // ---------------------------------------------------------------------------
  // Read path: front-page addressing and a two-stage sideband delay
  // ---------------------------------------------------------------------------
  logic              w_rd_in_win;
  int                w_front_base;
  logic [ADDR_W-1:0] w_raddr;
  logic [WORD_W-1:0] w_rdata;
  logic [1:0]        r_win_d;
  logic [1:0]        r_ad_d;
  logic [1:0]        r_hs_d;
  logic [1:0]        r_vs_d;
  logic              w_show;

  always_comb begin
    w_rd_in_win  = (int'(hcount_in) >= START_X) && (int'(hcount_in) < END_X) &&
                   (int'(vcount_in) >= START_Y) && (int'(vcount_in) < END_Y);
    w_front_base = ((DOUBLE_BUFFER != 0) && r_front_sel) ? PAGE : 0;
    w_raddr      = '0;
    if (w_rd_in_win) begin
      w_raddr = ADDR_W'((int'(hcount_in) - START_X) +
                        (int'(vcount_in) - START_Y) * W + w_front_base);
    end
  end

  window_ram #(
    .WIDTH  (WORD_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_in  (clk_in),
    .i_we    (w_wr_en),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so each shift stage
  // samples the previous stage's value from before the edge.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_win_d <= '0;
      r_ad_d  <= '0;
      r_hs_d  <= '0;
      r_vs_d  <= '0;
    end else begin
      r_win_d <= {r_win_d[0], w_rd_in_win};
      r_ad_d  <= {r_ad_d[0],  ad_in};
      r_hs_d  <= {r_hs_d[0],  hs_in};
      r_vs_d  <= {r_vs_d[0],  vs_in};
    end
  end

  assign w_show    = r_win_d[1] && r_ad_d[1];
  assign red_out   = w_show ? w_rdata[WORD_W-1 -: COLOR_BITS]     : '0;
  assign green_out = w_show ? w_rdata[2*COLOR_BITS-1 -: COLOR_BITS] : '0;
  assign blue_out  = w_show ? w_rdata[COLOR_BITS-1 -: COLOR_BITS]   : '0;
  assign hs_out    = r_hs_d[1];
  assign vs_out    = r_vs_d[1];

endmodule

// File: tb/tb_render_window_buffer.sv
// Directed plus randomized bench for render_window_buffer against a page/row/column pixel model.
`timescale 1ns/1ps
module tb_render_window_buffer;

  localparam int START_X = 390, START_Y = 390, END_X = 634, END_Y = 765;
  localparam int BAND_DIVIDE = 530, UPPER_OFFSET = 2, LOWER_OFFSET = 0;
  localparam int W = END_X - START_X, H = END_Y - START_Y;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [10:0] wr_hcount_in = '0;
  logic [9:0]  wr_vcount_in = '0;
  logic [23:0] wr_pixel_in = '0;
  logic        wr_valid_in = 1'b0;
  logic        wr_ready_out;
  logic        wr_frame_done_in = 1'b0;
  logic [10:0] hcount_in = '0;
  logic [9:0]  vcount_in = '0;
  logic        hs_in = 1'b0, vs_in = 1'b0, ad_in = 1'b0, nf_in = 1'b0;
  logic [3:0]  red_out, green_out, blue_out;
  logic        hs_out, vs_out, swap_out, front_sel_out;

  render_window_buffer dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .wr_hcount_in(wr_hcount_in), .wr_vcount_in(wr_vcount_in),
    .wr_pixel_in(wr_pixel_in), .wr_valid_in(wr_valid_in), .wr_ready_out(wr_ready_out),
    .wr_frame_done_in(wr_frame_done_in),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hs_in(hs_in), .vs_in(vs_in), .ad_in(ad_in), .nf_in(nf_in),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
    .hs_out(hs_out), .vs_out(vs_out), .swap_out(swap_out), .front_sel_out(front_sel_out)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: displayed page index, pending-swap flag, pixels keyed by page/row/column.
  int   m_front = 0;
  bit   m_pend  = 0;
  logic [11:0] ref_mem [int];

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] pix444(input logic [23:0] p);
    int v;
    v = (((int'(p) >> 20) & 15) << 8) | (((int'(p) >> 12) & 15) << 4) | ((int'(p) >> 4) & 15);
    return 12'(v);
  endfunction

  task automatic write_px(input int h, input int v, input logic [23:0] p);
    int off, col, row;
    wr_hcount_in = 11'(h);
    wr_vcount_in = 10'(v);
    wr_pixel_in  = p;
    wr_valid_in  = 1'b1;
    off = (v < BAND_DIVIDE) ? UPPER_OFFSET : LOWER_OFFSET;
    col = h - START_X - off;
    row = v - START_Y;
    if (!m_pend && col >= 0 && col < W && row >= 0 && row < H)
      ref_mem[(1 - m_front) * 1000000 + row * 1000 + col] = pix444(p);
    tick();
    wr_valid_in = 1'b0;
  endtask

  task automatic read_chk(input string tag, input int h, input int v, input logic ad);
    int col, row, key;
    logic [11:0] exp;
    bit known;
    hcount_in = 11'(h);
    vcount_in = 10'(v);
    ad_in     = ad;
    col = h - START_X;
    row = v - START_Y;
    known = 1;
    exp   = '0;
    if (ad && col >= 0 && col < W && row >= 0 && row < H) begin
      key = m_front * 1000000 + row * 1000 + col;
      if (ref_mem.exists(key)) exp = ref_mem[key];
      else known = 0;
    end
    tick();
    tick();
    if (known) check(tag, {red_out, green_out, blue_out}, exp);
    ad_in = 1'b0;
  endtask

  task automatic ctl(input string tag, input logic fd, input logic nf);
    bit exp_swap;
    wr_frame_done_in = fd;
    nf_in            = nf;
    exp_swap = 0;
    if (!m_pend) begin
      if (fd) m_pend = 1;
    end else if (nf) begin
      m_pend   = 0;
      m_front  = 1 - m_front;
      exp_swap = 1;
    end
    tick();
    wr_frame_done_in = 1'b0;
    nf_in            = 1'b0;
    check({tag, ".ready"}, wr_ready_out, !m_pend);
    check({tag, ".front"}, front_sel_out, m_front);
    check({tag, ".swap"}, swap_out, exp_swap);
  endtask

  task automatic do_reset(input string tag);
    rst_in = 1'b1;
    tick();
    tick();
    m_pend  = 0;
    m_front = 0;
    check({tag, ".ready"}, wr_ready_out, 1);
    check({tag, ".front"}, front_sel_out, 0);
    check({tag, ".swap"}, swap_out, 0);
    check({tag, ".rgb"}, {red_out, green_out, blue_out}, 0);
    check({tag, ".hs"}, hs_out, 0);
    check({tag, ".vs"}, vs_out, 0);
    rst_in = 1'b0;
  endtask

  task automatic read_front_page(input string tag);
    int pg, row, col;
    foreach (ref_mem[k]) begin
      pg  = k / 1000000;
      row = (k % 1000000) / 1000;
      col = k % 1000;
      if (pg == m_front) read_chk(tag, col + START_X, row + START_Y, 1'b1);
    end
  endtask

  initial begin
    do_reset("reset");

    // Directed writes into back page 1, including clipped neighbours.
    write_px(392, 390, 24'hFFFFFF);
    write_px(390, 600, 24'h123456);
    write_px(635, 390, 24'h7A5C3E);
    write_px(391, 391, 24'hABCDEF);
    write_px(392, 391, 24'h2468AC);
    write_px(636, 390, 24'h13579B);
    write_px(700, 300, 24'hDEADBE);

    ctl("frame_done", 1'b1, 1'b0);
    write_px(392, 390, 24'h000000);
    ctl("done_in_pending", 1'b1, 1'b0);
    ctl("nf_swap", 1'b0, 1'b1);
    ctl("after_swap", 1'b0, 1'b0);

    hcount_in = 11'd390; vcount_in = 10'd390; ad_in = 1'b1;
    tick(); tick();
    check("upper_band_fff", {red_out, green_out, blue_out}, 12'hFFF);
    hcount_in = 11'd390; vcount_in = 10'd600;
    tick(); tick();
    check("lower_band_135", {red_out, green_out, blue_out}, 12'h135);
    hcount_in = 11'd633; vcount_in = 10'd390;
    tick(); tick();
    check("x_neg_dropped", {red_out, green_out, blue_out}, 12'h753);
    hcount_in = 11'd390; vcount_in = 10'd391;
    tick(); tick();
    check("x_ge_w_dropped", {red_out, green_out, blue_out}, 12'h26A);
    hcount_in = 11'd389; vcount_in = 10'd390;
    tick(); tick();
    check("col_389_black", {red_out, green_out, blue_out}, 12'h000);
    hcount_in = 11'd390; vcount_in = 10'd390; ad_in = 1'b0;
    tick(); tick();
    check("ad_low_black", {red_out, green_out, blue_out}, 12'h000);

    hs_in = 1'b1; vs_in = 1'b1;
    tick(); check("hs_lag1", hs_out, 0); check("vs_lag1", vs_out, 0);
    tick(); check("hs_lag2", hs_out, 1); check("vs_lag2", vs_out, 1);
    hs_in = 1'b0;
    tick(); check("hs_fall1", hs_out, 1);
    tick(); check("hs_fall2", hs_out, 0); check("vs_hold", vs_out, 1);
    vs_in = 1'b0;

    // Random writes into page 0, then a coincident done/new-frame that must not swap.
    for (int i = 0; i < 150; i++)
      write_px(int'($urandom_range(370, 660)), int'($urandom_range(380, 780)), 24'($urandom));
    ctl("done_and_nf", 1'b1, 1'b1);
    ctl("nf_second", 1'b0, 1'b1);
    read_front_page("page0_rand");

    ctl("fd2", 1'b1, 1'b0);
    ctl("nf2", 1'b0, 1'b1);
    read_front_page("page1_all");

    // Abandon a pending swap with reset while the sync inputs are high.
    for (int i = 0; i < 40; i++)
      write_px(int'($urandom_range(390, 640)), int'($urandom_range(390, 770)), 24'($urandom));
    ctl("fd3", 1'b1, 1'b0);
    hs_in = 1'b1; vs_in = 1'b1;
    do_reset("reset_pending");
    hs_in = 1'b0; vs_in = 1'b0;
    read_front_page("page0_after_reset");

    for (int i = 0; i < 120; i++)
      read_chk("rand_read", int'($urandom_range(380, 645)), int'($urandom_range(385, 770)),
               1'($urandom_range(0, 1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
